// File: rtl/piso_shift_register_pkg.sv
// piso_pkg: shared state encoding and counter sizing for the PISO transmitter.
`default_nettype none

package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    function automatic int count_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/piso_shift_register_if.sv
// piso_shift_register_if: load handshake plus serial output bundle.
`default_nettype none

interface piso_shift_register_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pi_data;
    logic             so;
    logic             so_valid;
    logic             so_last;

    modport master (
        output load_valid, pi_data,
        input  load_ready, so, so_valid, so_last
    );

    modport slave (
        input  load_valid, pi_data,
        output load_ready, so, so_valid, so_last
    );
endinterface

`default_nettype wire

// File: rtl/piso_shift_register_bit_counter.sv
// piso_bit_counter: bit index within a frame; saturates at WIDTH-1 and flags it.
`default_nettype none

module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load_zero_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int CW = count_width(WIDTH);
    localparam logic [CW-1:0] TC_VALUE = CW'(WIDTH - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tc_o = (count_q == TC_VALUE);

    always_comb begin
        count_d = count_q;
        if (load_zero_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/piso_shift_register.sv
// piso_shift_register: valid/ready loaded, MSB-first serialiser.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
`default_nettype none

module piso_shift_register
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    piso_shift_register_if.slave bus
);
    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic             ready_raw;
    logic             load_ready;
    logic             so;
    logic             so_valid;
    logic             so_last;
`ifdef PISO_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    piso_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .load_zero_i(cnt_clr),
        .en_i       (cnt_en),
        .tc_o       (cnt_tc)
    );

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        ready_raw = 1'b0;
        so        = 1'b0;
        so_valid  = 1'b0;
        so_last   = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d  = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                ready_raw = 1'b1;
            end
            ST_SHIFT: begin
                so       = sreg_q[WIDTH-1];
                so_valid = 1'b1;
                sreg_d   = sreg_q << 1;
                cnt_en   = 1'b1;
                if (cnt_tc) begin
`ifdef PISO_PARITY_EN
                    state_d   = ST_PARITY;
`else
                    so_last   = 1'b1;
                    ready_raw = 1'b1;
                    state_d   = ST_IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                so        = parity_q;
                so_valid  = 1'b1;
                so_last   = 1'b1;
                ready_raw = 1'b1;
                state_d   = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Ready is held low while reset is asserted; a handshake overrides the
        // default return to IDLE so back-to-back words leave no gap.
        load_ready = ready_raw & rst;
        if (bus.load_valid && load_ready) begin
            sreg_d  = bus.pi_data;
            cnt_clr = 1'b1;
            state_d = ST_SHIFT;
`ifdef PISO_PARITY_EN
            parity_d = ^bus.pi_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            sreg_q   <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.so         = so;
    assign bus.so_valid   = so_valid;
    assign bus.so_last    = so_last;

endmodule

`default_nettype wire
